// File: rtl/key_sched_pkg.sv
// rtl/key_sched_pkg.sv - shared types and constants for the key search scheduler
package key_sched_pkg;

  localparam int KEY_W_DEF = 24;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_LO,
    WAIT_HI,
    EVAL
  } state_t;

endpackage

// File: rtl/key_sched.sv
// rtl/key_sched.sv - brute-force key stepper driving one decryption core
// Walks KEY_START, KEY_START+KEY_STRIDE, ... until the core reports printable plaintext.
module key_sched
  import key_sched_pkg::*;
#(
  parameter int     KEY_W      = KEY_W_DEF,
  parameter longint KEY_START  = 0,
  parameter longint KEY_STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  input  logic             stop,
  output logic             core_en,
  input  logic             core_rdy,
  output logic [KEY_W-1:0] core_key,
  input  logic             core_ok,
  output logic             done,
  output logic             key_valid,
  output logic [KEY_W-1:0] key,
  output logic [KEY_W:0]   tries
);

  localparam longint KEY_MAX = (KEY_W >= 63) ? 64'sh7FFF_FFFF_FFFF_FFFF
                                             : ((64'sd1 <<< KEY_W) - 64'sd1);
  localparam logic [KEY_W:0] MAX_W = {1'b0, {KEY_W{1'b1}}};
  // A stride wider than the key space simply makes every key the last one.
  localparam logic [KEY_W:0] STEP  = (KEY_STRIDE > KEY_MAX) ? MAX_W + 1'b1
                                                            : (KEY_W+1)'(KEY_STRIDE);

  if (KEY_W < 1) begin : g_bad_width
    $error("key_sched: KEY_W must be at least 1");
  end
  if (KEY_START < 0 || KEY_START > KEY_MAX) begin : g_bad_start
    $error("key_sched: KEY_START outside the key space");
  end
  if (KEY_STRIDE < 1) begin : g_bad_stride
    $error("key_sched: KEY_STRIDE must be at least 1");
  end

  state_t           state, nxt;
  logic [KEY_W-1:0] cur;
  logic [KEY_W:0]   sum;
  logic             last;
  logic             ok_r;

  // The carry out of the extended add marks the final key, so cur never wraps.
  assign sum      = {1'b0, cur} + STEP;
  assign last     = sum[KEY_W];
  assign rdy      = (state == IDLE);
  assign core_key = cur;

  always_comb begin
    nxt     = state;
    core_en = 1'b0;
    case (state)
      IDLE:    if (en) nxt = LAUNCH;
      LAUNCH: begin
        if (core_rdy) begin
          core_en = 1'b1;
          nxt     = WAIT_LO;
        end
      end
      WAIT_LO: if (!core_rdy) nxt = WAIT_HI;
      WAIT_HI: if (core_rdy) nxt = EVAL;
      EVAL:    nxt = (ok_r || last || stop) ? IDLE : LAUNCH;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      ok_r      <= 1'b0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      key       <= '0;
      tries     <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (en) begin
            cur       <= KEY_W'(KEY_START);
            done      <= 1'b0;
            key_valid <= 1'b0;
            key       <= '0;
            tries     <= '0;
          end
        end
        WAIT_HI: begin
          if (core_rdy) begin
            ok_r  <= core_ok;
            tries <= tries + 1'b1;
          end
        end
        // A hit outranks both exhaustion and a sibling's stop.
        EVAL: begin
          if (ok_r) begin
            key       <= cur;
            key_valid <= 1'b1;
            done      <= 1'b1;
          end else if (last || stop) begin
            done      <= 1'b1;
          end else begin
            cur       <= sum[KEY_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
